// File: rtl/multdiv_seq_pkg.sv
// Shared definitions for the iterative multiply/divide unit.
//   state_e    : 2-bit controller state encoding
//   ALU_MUL/DIV: ALU opcodes that select the unit in the execute stage
//   MD_WIDTH   : default operand/result width
package multdiv_seq_pkg;

  localparam int MD_WIDTH = 32;

  localparam logic [4:0] ALU_MUL = 5'b00110;
  localparam logic [4:0] ALU_DIV = 5'b00111;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_MUL  = 2'b01,
    ST_DIV  = 2'b10,
    ST_DONE = 2'b11
  } state_e;

endpackage

// File: rtl/multdiv_abs_neg.sv
// Conditional two's-complement negate.
//   value  : WIDTH-bit input
//   negate : 1 -> result = -value, 0 -> result = value
//   result : WIDTH-bit output
// Used both to take operand magnitudes (negate = sign bit) and to apply the
// final result sign.  The magnitude of the most negative value comes out as
// the same bit pattern, which is correct when read as unsigned.
module multdiv_abs_neg
  import multdiv_seq_pkg::*;
#(
  parameter int WIDTH = MD_WIDTH
) (
  input  logic [WIDTH-1:0] value,
  input  logic             negate,
  output logic [WIDTH-1:0] result
);

  assign result = negate ? (~value + WIDTH'(1'b1)) : value;

endmodule

// File: rtl/multdiv_seq.sv
// Iterative signed multiply/divide unit for the execute stage.
// While an operation runs it freezes F/D/X (stall_fdx) and bubbles X/M
// (nops_to_xm); on completion it pulses result_rdy with the result.
// Ports:
//   clock, reset (async, active-low)
//   ctrl_MULT / ctrl_DIV : start pulses, sampled only in IDLE (MULT wins)
//   data_A / data_B      : signed operands
//   rd_in                : destination tag of the issuing instruction
//   stall_fdx/nops_to_xm : combinational freeze / bubble controls
//   result_rdy           : one-cycle result-valid pulse (registered)
//   data_result          : product low word / quotient (registered, held)
//   data_exception       : overflow or divide-by-zero (registered, held)
//   rd_out               : latched destination tag (registered, held)
module multdiv_seq
  import multdiv_seq_pkg::*;
#(
  parameter int WIDTH = MD_WIDTH
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             ctrl_MULT,
  input  logic             ctrl_DIV,
  input  logic [WIDTH-1:0] data_A,
  input  logic [WIDTH-1:0] data_B,
  input  logic [4:0]       rd_in,
  output logic             stall_fdx,
  output logic             nops_to_xm,
  output logic             result_rdy,
  output logic [WIDTH-1:0] data_result,
  output logic             data_exception,
  output logic [4:0]       rd_out
);

  localparam int CNT_W = $clog2(WIDTH);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

  // Product magnitude overflows the signed low word when it cannot be
  // represented after applying the sign: > 2^(W-1)-1 positive, > 2^(W-1) negative.
  function automatic logic mul_overflow(input logic [2*WIDTH-1:0] mag, input logic neg);
    logic ovf;
    if (neg) begin
      ovf = (|mag[2*WIDTH-1:WIDTH]) | (mag[WIDTH-1] & (|mag[WIDTH-2:0]));
    end else begin
      ovf = |mag[2*WIDTH-1:WIDTH-1];
    end
    return ovf;
  endfunction

  state_e             state_r;
  state_e             state_next_s;
  logic [CNT_W-1:0]   count_r;
  logic [2*WIDTH-1:0] acc_r;        // mul: {partial product, multiplier}; div: {remainder, dividend/quotient}
  logic [WIDTH-1:0]   operand_r;    // multiplicand or divisor magnitude
  logic               a_sign_r;
  logic               b_sign_r;
  logic               div0_r;
  logic [4:0]         op_r;
  logic [4:0]         rd_r;

  logic               result_rdy_r;
  logic [WIDTH-1:0]   data_result_r;
  logic               data_exception_r;
  logic [4:0]         rd_out_r;

  logic               start_mul_s;
  logic               start_div_s;
  logic               b_zero_s;
  logic               stall_s;
  logic [WIDTH-1:0]   a_mag_s;
  logic [WIDTH-1:0]   b_mag_s;

  logic [WIDTH:0]     mul_sum_s;
  logic [2*WIDTH-1:0] mul_next_s;
  logic [WIDTH:0]     div_rem_shift_s;
  logic [WIDTH:0]     div_trial_s;
  logic               div_ge_s;
  logic [WIDTH-1:0]   div_rem_next_s;
  logic [2*WIDTH-1:0] div_next_s;

  logic               sign_s;
  logic [WIDTH-1:0]   raw_result_s;
  logic [WIDTH-1:0]   result_s;
  logic               exception_s;

  multdiv_abs_neg #(.WIDTH(WIDTH)) u_abs_a (
    .value  (data_A),
    .negate (data_A[WIDTH-1]),
    .result (a_mag_s)
  );

  multdiv_abs_neg #(.WIDTH(WIDTH)) u_abs_b (
    .value  (data_B),
    .negate (data_B[WIDTH-1]),
    .result (b_mag_s)
  );

  multdiv_abs_neg #(.WIDTH(WIDTH)) u_fix_sign (
    .value  (raw_result_s),
    .negate (sign_s),
    .result (result_s)
  );

  // Start decode: MULT has priority when both pulses arrive together.
  always_comb begin
    start_mul_s = 1'b0;
    start_div_s = 1'b0;
    b_zero_s    = (data_B == {WIDTH{1'b0}});
    if (state_r == ST_IDLE) begin
      start_mul_s = ctrl_MULT;
      start_div_s = ~ctrl_MULT & ctrl_DIV;
    end else begin
      start_mul_s = 1'b0;
      start_div_s = 1'b0;
    end
  end

  // Next-state logic and freeze/bubble controls.
  always_comb begin
    state_next_s = state_r;
    stall_s      = 1'b0;
    case (state_r)
      ST_IDLE: begin
        stall_s = start_mul_s | start_div_s;
        if (start_mul_s) begin
          state_next_s = ST_MUL;
        end else if (start_div_s) begin
          // Divide-by-zero needs no iterations.
          state_next_s = b_zero_s ? ST_DONE : ST_DIV;
        end else begin
          state_next_s = ST_IDLE;
        end
      end
      ST_MUL: begin
        stall_s = 1'b1;
        if (count_r == CNT_LAST) begin
          state_next_s = ST_DONE;
        end else begin
          state_next_s = ST_MUL;
        end
      end
      ST_DIV: begin
        stall_s = 1'b1;
        if (count_r == CNT_LAST) begin
          state_next_s = ST_DONE;
        end else begin
          state_next_s = ST_DIV;
        end
      end
      ST_DONE: begin
        stall_s      = 1'b0;
        state_next_s = ST_IDLE;
      end
      default: begin
        stall_s      = 1'b0;
        state_next_s = ST_IDLE;
      end
    endcase
  end

  // One iteration of shift-add multiply and restoring divide.
  always_comb begin
    mul_sum_s       = {1'b0, acc_r[2*WIDTH-1:WIDTH]}
                    + (acc_r[0] ? {1'b0, operand_r} : {(WIDTH+1){1'b0}});
    mul_next_s      = {mul_sum_s, acc_r[WIDTH-1:1]};
    div_rem_shift_s = {acc_r[2*WIDTH-1:WIDTH], acc_r[WIDTH-1]};
    div_trial_s     = div_rem_shift_s - {1'b0, operand_r};
    div_ge_s        = (div_rem_shift_s >= {1'b0, operand_r});
    if (div_ge_s) begin
      div_rem_next_s = div_trial_s[WIDTH-1:0];
    end else begin
      div_rem_next_s = div_rem_shift_s[WIDTH-1:0];
    end
    div_next_s      = {div_rem_next_s, acc_r[WIDTH-2:0], div_ge_s};
  end

  // Final sign fix-up and exception detection, consumed in DONE.
  always_comb begin
    sign_s       = a_sign_r ^ b_sign_r;
    raw_result_s = acc_r[WIDTH-1:0];
    exception_s  = 1'b0;
    if (div0_r) begin
      sign_s       = 1'b0;
      raw_result_s = {WIDTH{1'b0}};
      exception_s  = 1'b1;
    end else if (op_r == ALU_MUL) begin
      exception_s  = mul_overflow(acc_r, a_sign_r ^ b_sign_r);
    end else begin
      // Only MIN / -1 gives a positive quotient that does not fit.
      exception_s  = ~(a_sign_r ^ b_sign_r) & acc_r[WIDTH-1];
    end
  end

  // Controller state register.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_next_s;
    end
  end

  // Operand capture and iteration datapath.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      count_r   <= {CNT_W{1'b0}};
      acc_r     <= {(2*WIDTH){1'b0}};
      operand_r <= {WIDTH{1'b0}};
      a_sign_r  <= 1'b0;
      b_sign_r  <= 1'b0;
      div0_r    <= 1'b0;
      op_r      <= 5'b00000;
      rd_r      <= 5'b00000;
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (start_mul_s || start_div_s) begin
            acc_r     <= {{WIDTH{1'b0}}, (start_mul_s ? b_mag_s : a_mag_s)};
            operand_r <= start_mul_s ? a_mag_s : b_mag_s;
            a_sign_r  <= data_A[WIDTH-1];
            b_sign_r  <= data_B[WIDTH-1];
            div0_r    <= start_div_s & b_zero_s;
            op_r      <= start_mul_s ? ALU_MUL : ALU_DIV;
            rd_r      <= rd_in;
            count_r   <= {CNT_W{1'b0}};
          end
        end
        ST_MUL: begin
          acc_r   <= mul_next_s;
          count_r <= count_r + CNT_W'(1);
        end
        ST_DIV: begin
          acc_r   <= div_next_s;
          count_r <= count_r + CNT_W'(1);
        end
        ST_DONE: begin
          count_r <= {CNT_W{1'b0}};
        end
        default: begin
          count_r <= {CNT_W{1'b0}};
        end
      endcase
    end
  end

  // Result registers: loaded on leaving DONE and held until the next completion.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      result_rdy_r     <= 1'b0;
      data_result_r    <= {WIDTH{1'b0}};
      data_exception_r <= 1'b0;
      rd_out_r         <= 5'b00000;
    end else begin
      result_rdy_r <= (state_r == ST_DONE);
      if (state_r == ST_DONE) begin
        data_result_r    <= result_s;
        data_exception_r <= exception_s;
        rd_out_r         <= rd_r;
      end
    end
  end

  assign stall_fdx      = stall_s;
  assign nops_to_xm     = stall_s;
  assign result_rdy     = result_rdy_r;
  assign data_result    = data_result_r;
  assign data_exception = data_exception_r;
  assign rd_out         = rd_out_r;

endmodule

// File: tb/tb_multdiv_seq.sv
// Self-checking bench for multdiv_seq: directed corner cases plus random
// operands, each compared against a plain-arithmetic reference model.
module tb_multdiv_seq;

  logic        clock = 1'b0;
  logic        reset;
  logic        ctrl_MULT;
  logic        ctrl_DIV;
  logic [31:0] data_A;
  logic [31:0] data_B;
  logic [4:0]  rd_in;
  logic        stall_fdx;
  logic        nops_to_xm;
  logic        result_rdy;
  logic [31:0] data_result;
  logic        data_exception;
  logic [4:0]  rd_out;

  int n_checks = 0;
  int n_errors = 0;

  multdiv_seq #(.WIDTH(32)) dut (
    .clock          (clock),
    .reset          (reset),
    .ctrl_MULT      (ctrl_MULT),
    .ctrl_DIV       (ctrl_DIV),
    .data_A         (data_A),
    .data_B         (data_B),
    .rd_in          (rd_in),
    .stall_fdx      (stall_fdx),
    .nops_to_xm     (nops_to_xm),
    .result_rdy     (result_rdy),
    .data_result    (data_result),
    .data_exception (data_exception),
    .rd_out         (rd_out)
  );

  always #5 clock = ~clock;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Signed reference: 64-bit product / truncating quotient.
  function automatic void ref_model(input bit is_mul, input logic [31:0] a, input logic [31:0] b,
                                    output logic [31:0] r, output logic e);
    longint p;
    int     q;
    if (is_mul) begin
      p = longint'($signed(a)) * longint'($signed(b));
      r = p[31:0];
      e = (p != longint'($signed(r)));
    end else if (b == 32'd0) begin
      r = 32'd0;
      e = 1'b1;
    end else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
      r = 32'h8000_0000;
      e = 1'b1;
    end else begin
      q = $signed(a) / $signed(b);
      r = q;
      e = 1'b0;
    end
  endfunction

  task automatic run_op(input string name, input bit mul, input bit div,
                        input logic [31:0] a, input logic [31:0] b, input logic [4:0] rd);
    logic [31:0] er;
    logic        ee;
    int          exp_lat;
    int          lat;
    int          stall_cnt;
    bit          nops_ok;
    bit          rdy;
    ref_model(mul, a, b, er, ee);
    exp_lat = (!mul && b == 32'd0) ? 1 : 33;
    @(negedge clock);
    ctrl_MULT = mul;
    ctrl_DIV  = div;
    data_A    = a;
    data_B    = b;
    rd_in     = rd;
    #1;
    check_eq($sformatf("%s.issue_stall", name), {62'd0, stall_fdx, nops_to_xm}, 64'd3);
    lat       = -1;
    stall_cnt = 0;
    nops_ok   = 1'b1;
    for (int i = 1; i <= 40; i++) begin
      @(posedge clock);
      @(negedge clock);
      rdy = result_rdy;
      if (stall_fdx) stall_cnt++;
      if (nops_to_xm !== stall_fdx) nops_ok = 1'b0;
      if (i == 1) begin
        // Operands must be latched: scramble them once the op has started.
        ctrl_MULT = 1'b0;
        ctrl_DIV  = 1'b0;
        data_A    = $urandom;
        data_B    = $urandom;
        rd_in     = 5'($urandom);
      end
      if (rdy) begin
        lat = i - 1;
        break;
      end
    end
    check_eq($sformatf("%s.latency", name), 64'(lat), 64'(exp_lat));
    check_eq($sformatf("%s.stall_cycles", name), 64'(stall_cnt), 64'(exp_lat - 1));
    check_eq($sformatf("%s.nops_eq_stall", name), {63'd0, nops_ok}, 64'd1);
    check_eq($sformatf("%s.result", name), {32'd0, data_result}, {32'd0, er});
    check_eq($sformatf("%s.exception", name), {63'd0, data_exception}, {63'd0, ee});
    check_eq($sformatf("%s.rd_out", name), {59'd0, rd_out}, {59'd0, rd});
    @(posedge clock);
    @(negedge clock);
    check_eq($sformatf("%s.rdy_pulse", name), {63'd0, result_rdy}, 64'd0);
    check_eq($sformatf("%s.hold", name), {32'd0, data_result}, {32'd0, er});
  endtask

  initial begin
    #500000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

  initial begin
    int rdy_seen;
    bit m;
    logic [31:0] ra;
    logic [31:0] rb;

    reset     = 1'b0;
    ctrl_MULT = 1'b0;
    ctrl_DIV  = 1'b0;
    data_A    = 32'd0;
    data_B    = 32'd0;
    rd_in     = 5'd0;
    #3;
    check_eq("reset.outputs",
             {26'd0, stall_fdx, nops_to_xm, result_rdy, data_exception, rd_out, data_result},
             64'd0);
    repeat (2) @(negedge clock);
    reset = 1'b1;

    run_op("mul_7x-6",      1'b1, 1'b0, 32'd7,          32'hFFFF_FFFA, 5'd3);
    run_op("mul_ovf",       1'b1, 1'b0, 32'h0001_0000,  32'h0001_0000, 5'd9);
    run_op("div_-7/2",      1'b0, 1'b1, 32'hFFFF_FFF9,  32'd2,         5'd17);
    run_op("div_5/0",       1'b0, 1'b1, 32'd5,          32'd0,         5'd30);
    run_op("div_min/-1",    1'b0, 1'b1, 32'h8000_0000,  32'hFFFF_FFFF, 5'd1);
    run_op("both_3x4",      1'b1, 1'b1, 32'd3,          32'd4,         5'd12);
    run_op("mul_min_x1",    1'b1, 1'b0, 32'h8000_0000,  32'd1,         5'd5);
    run_op("mul_min_x-1",   1'b1, 1'b0, 32'h8000_0000,  32'hFFFF_FFFF, 5'd6);
    run_op("div_min/1",     1'b0, 1'b1, 32'h8000_0000,  32'd1,         5'd7);
    run_op("div_3/-7",      1'b0, 1'b1, 32'd3,          32'hFFFF_FFF9, 5'd8);

    // Reset in the middle of a multiply.
    @(negedge clock);
    ctrl_MULT = 1'b1;
    data_A    = 32'd12345;
    data_B    = 32'd678;
    rd_in     = 5'd4;
    @(posedge clock);
    @(negedge clock);
    ctrl_MULT = 1'b0;
    repeat (9) @(posedge clock);
    @(negedge clock);
    check_eq("abort.stall_before", {63'd0, stall_fdx}, 64'd1);
    reset = 1'b0;
    #1;
    check_eq("abort.stall_after", {62'd0, stall_fdx, nops_to_xm}, 64'd0);
    check_eq("abort.rdy", {63'd0, result_rdy}, 64'd0);
    repeat (2) @(negedge clock);
    reset    = 1'b1;
    rdy_seen = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clock);
      if (result_rdy) rdy_seen++;
    end
    check_eq("abort.no_rdy", 64'(rdy_seen), 64'd0);
    run_op("after_abort", 1'b1, 1'b0, 32'd12345, 32'd678, 5'd4);

    // Random operands, mixing wide, narrow and zero divisors.
    for (int k = 0; k < 30; k++) begin
      m  = k[0];
      ra = $urandom;
      rb = $urandom;
      if (k % 3 == 0) rb = {{24{rb[31]}}, rb[7:0]};
      if (k % 4 == 1) ra = {{16{ra[31]}}, ra[15:0]};
      if (!m && k % 10 == 4) rb = 32'd0;
      run_op($sformatf("rand%0d", k), m, ~m, ra, rb, 5'($urandom));
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
